// File: rtl/df_pkg.sv
// Shared constants and helpers for the df_clk_div clock divider family.
package df_pkg;

    // Smallest legal divide ratio.
    localparam int DF_DIV_MIN = 1;

    // Divide ratio that yields 1 Hz from the 50 MHz board clock.
    localparam int DF_DIV_1HZ_50M = 25000000;

    // Counter width needed to hold 0..div-1, never narrower than one bit.
    function automatic int unsigned df_cw(input int div);
        int unsigned w;
        w = (div <= 1) ? 32'd0 : 32'($clog2(div));
        return (w < 32'd1) ? 32'd1 : w;
    endfunction

endpackage : df_pkg

// File: rtl/df_modn_counter.sv
// Mod-N up-counter with asynchronous active-low clear and a combinational
// wrap strobe that is high while the count sits at N-1.
module df_modn_counter
    import df_pkg::*;
#(
    parameter int          N = 2,
    parameter int unsigned W = df_cw(N)
) (
    input  logic clock,
    input  logic reset,
    output logic wrap_c
);

    // Terminal count value, sized to the counter.
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt;

    // Reject ratios below the legal minimum at elaboration time.
    if (N < DF_DIV_MIN) begin : g_bad_n
        $error("df_modn_counter: N=%0d is below the minimum of %0d", N, DF_DIV_MIN);
    end

    // Terminal count detect; drives both the wrap and the caller's toggle.
    assign wrap_c = (cnt == LAST);

    // Count 0..N-1 and wrap back to 0 on the edge that sees N-1.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (wrap_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule : df_modn_counter

// File: rtl/df_clk_div.sv
// Integer clock divider: clk_i toggles every DIV input cycles, giving a
// 50 % duty-cycle output with period 2*DIV. clk_i is a register output and
// must be constrained as a generated clock by any consumer that clocks on it.
// Optional feature macro: DF_TICK_EN adds a one-cycle tick output that is
// high in the cycle holding each new clk_i value, for clock-enable use.
module df_clk_div
    import df_pkg::*;
#(
    parameter int DIV = DF_DIV_1HZ_50M
) (
    input  logic clock,
    input  logic reset,
`ifdef DF_TICK_EN
    output logic clk_i,
    output logic tick
`else
    output logic clk_i
`endif
);

    // Counter width covering 0..DIV-1.
    localparam int unsigned CW = df_cw(DIV);

    logic wrap_c;

    // Reject ratios below the legal minimum at elaboration time.
    if (DIV < DF_DIV_MIN) begin : g_bad_div
        $fatal(1, "df_clk_div: DIV=%0d is below the minimum of %0d", DIV, DF_DIV_MIN);
    end

    // Phase counter; wrap_c marks the edge on which the output flips.
    df_modn_counter #(
        .N (DIV),
        .W (CW)
    ) u_cnt (
        .clock  (clock),
        .reset  (reset),
        .wrap_c (wrap_c)
    );

    // Output clock register, flipped on every counter wrap.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_i <= 1'b0;
        end else if (wrap_c) begin
            clk_i <= ~clk_i;
        end
    end

`ifdef DF_TICK_EN
    // Strobe registered alongside clk_i so it lines up with the new level.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tick <= 1'b0;
        end else begin
            tick <= wrap_c;
        end
    end
`endif

endmodule : df_clk_div

// File: tb/tb_df_clk_div.sv
// Directed bench for df_clk_div across several divide ratios.
// Build with +define+DF_TICK_EN to also check the tick strobe.
module tb_df_clk_div;

    logic clock;
    logic r4, r1, r5, r7, r3, rb;
    logic c4, c1, c5, c7, c3, cb;
`ifdef DF_TICK_EN
    logic t4, t1, t5, t7, t3, tb_;
`endif

    int n_cmp;
    int n_bad;

    initial clock = 1'b0;
    always #5 clock = ~clock;

`ifdef DF_TICK_EN
    df_clk_div #(.DIV(4))        dut4 (.clock(clock), .reset(r4), .clk_i(c4), .tick(t4));
    df_clk_div #(.DIV(1))        dut1 (.clock(clock), .reset(r1), .clk_i(c1), .tick(t1));
    df_clk_div #(.DIV(5))        dut5 (.clock(clock), .reset(r5), .clk_i(c5), .tick(t5));
    df_clk_div #(.DIV(7))        dut7 (.clock(clock), .reset(r7), .clk_i(c7), .tick(t7));
    df_clk_div #(.DIV(3))        dut3 (.clock(clock), .reset(r3), .clk_i(c3), .tick(t3));
    df_clk_div #(.DIV(25000000)) dutb (.clock(clock), .reset(rb), .clk_i(cb), .tick(tb_));
`else
    df_clk_div #(.DIV(4))        dut4 (.clock(clock), .reset(r4), .clk_i(c4));
    df_clk_div #(.DIV(1))        dut1 (.clock(clock), .reset(r1), .clk_i(c1));
    df_clk_div #(.DIV(5))        dut5 (.clock(clock), .reset(r5), .clk_i(c5));
    df_clk_div #(.DIV(7))        dut7 (.clock(clock), .reset(r7), .clk_i(c7));
    df_clk_div #(.DIV(3))        dut3 (.clock(clock), .reset(r3), .clk_i(c3));
    df_clk_div #(.DIV(25000000)) dutb (.clock(clock), .reset(rb), .clk_i(cb));
`endif

    // Compare one observed value against its expected value.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic get_clk(input int id);
        case (id)
            4:       return c4;
            1:       return c1;
            5:       return c5;
            7:       return c7;
            3:       return c3;
            default: return cb;
        endcase
    endfunction

    function automatic logic [31:0] get_cnt(input int id);
        case (id)
            4:       return 32'(dut4.u_cnt.cnt);
            1:       return 32'(dut1.u_cnt.cnt);
            5:       return 32'(dut5.u_cnt.cnt);
            7:       return 32'(dut7.u_cnt.cnt);
            3:       return 32'(dut3.u_cnt.cnt);
            default: return 32'(dutb.u_cnt.cnt);
        endcase
    endfunction

`ifdef DF_TICK_EN
    function automatic logic get_tick(input int id);
        case (id)
            4:       return t4;
            1:       return t1;
            5:       return t5;
            7:       return t7;
            3:       return t3;
            default: return tb_;
        endcase
    endfunction
`endif

    // Walk n edges (numbered from first_e after release) checking the phase.
    task automatic run_edges(input int div, input int first_e, input int n);
        for (int e = first_e; e < first_e + n; e++) begin
            @(posedge clock);
            #1;
            chk($sformatf("clk_i div%0d e%0d", div, e), 32'(get_clk(div)), 32'((e / div) % 2));
            chk($sformatf("cnt div%0d e%0d", div, e), get_cnt(div), 32'(e % div));
`ifdef DF_TICK_EN
            chk($sformatf("tick div%0d e%0d", div, e), 32'(get_tick(div)), 32'((e % div) == 0));
`endif
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        {r4, r1, r5, r7, r3, rb} = '0;

        // Reset hold: output and counter stay cleared across edges.
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("reset_hold clk_i", 32'(c4), 32'd0);
            chk("reset_hold cnt", get_cnt(4), 32'd0);
`ifdef DF_TICK_EN
            chk("reset_hold tick", 32'(t4), 32'd0);
`endif
        end

        // DIV=4: rise on edge 4, fall on edge 8, ten full periods.
        @(negedge clock) r4 = 1'b1;
        run_edges(4, 1, 80);

        // DIV=1: toggles every edge.
        @(negedge clock) r1 = 1'b1;
        run_edges(1, 1, 16);

        // DIV=7: twenty periods of 7 high / 7 low.
        @(negedge clock) r7 = 1'b1;
        run_edges(7, 1, 280);

        // DIV=3: ten periods, tick twice per six cycles.
        @(negedge clock) r3 = 1'b1;
        run_edges(3, 1, 60);

        // DIV=5: reset asserted between edges while high at cnt=2.
        @(negedge clock) r5 = 1'b1;
        run_edges(5, 1, 7);
        @(negedge clock);
        chk("midreset pre clk_i", 32'(c5), 32'd1);
        chk("midreset pre cnt", get_cnt(5), 32'd2);
        #2 r5 = 1'b0;
        #1;
        chk("midreset async clk_i", 32'(c5), 32'd0);
        chk("midreset async cnt", get_cnt(5), 32'd0);
        @(negedge clock);
        chk("midreset held clk_i", 32'(c5), 32'd0);
        r5 = 1'b1;
        run_edges(5, 1, 12);

        // Large ratio: no toggle and a wide counter still climbing.
        @(negedge clock) rb = 1'b1;
        repeat (1000) @(posedge clock);
        #1;
        chk("big clk_i", 32'(cb), 32'd0);
        chk("big cnt", get_cnt(0), 32'd1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_df_clk_div

// File: doc/df_clk_div.md
Name: df_clk_div

Overview:
Parameterised integer clock divider for the board's 50 MHz system clock.
- Produces a 50 % duty-cycle divided clock-enable/clock signal that toggles once every DIV input cycles, giving an output period of 2*DIV input cycles.
- Used by top-level designs to derive slow clocks for LED blinking and timebases, e.g. DIV=25000000 gives 1 Hz from 50 MHz.

Parameters:
- DIV, 25000000, number of input clock cycles between output toggles; legal range 1 to 2^31-1.
- CW, derived, counter width = max(1, $clog2(DIV)); localparam, not overridable.

Ports:
- clock  input  1  system clock; all sequential logic on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- clk_i  output 1  divided output; registered, glitch-free, 50 % duty cycle.
- tick   output 1  (only with DF_TICK_EN) one-clock strobe coincident with every clk_i toggle.

Behaviour:
- Internal counter cnt[CW-1:0] and output register clk_i.
- While reset=0, asynchronously: cnt=0, clk_i=0, tick=0. Reset takes effect immediately, without waiting for a clock edge.
- On each rising clock edge with reset=1:
  - if cnt==DIV-1, then cnt<=0 and clk_i<=~clk_i;
  - otherwise cnt<=cnt+1 and clk_i holds.
- Latency after reset release: the first clk_i rise occurs on the DIV-th rising edge. clk_i is then high for DIV cycles, low for DIV cycles, and repeats.
- Output period is exactly 2*DIV clock cycles with no drift; cnt never exceeds DIV-1.
- Wrap: the cnt==DIV-1 to 0 transition and the toggle happen on the same edge.
- DIV=1: cnt is constantly 0 and clk_i toggles every edge (clock/2).
- Reset asserted mid-count: cnt and clk_i clear at once, regardless of phase. After release, counting restarts from 0 and the full DIV cycles elapse before the next toggle.
- Reset release coincident with a clock edge: that edge does not count. The first counted edge is the next one.
- DIV<1 is rejected at elaboration with a $error / $fatal.
- clk_i is a register output and may drive a clock or asynchronous-reset domain. Consumers must treat it as a generated clock with its own timing constraint.
- Integration: the board buttons are pull-up and active-low, so a button maps to reset directly without inversion.

Optional Feature:
Macro DF_TICK_EN.
- Defined:
  - adds output port tick;
  - tick=1 for exactly one clock cycle on the cycle following each edge where cnt wraps, i.e. aligned with the new clk_i value;
  - tick=0 at reset.
  - With DIV=1, tick is constantly 1 after the first edge.
  - Lets consumers stay in the clock domain using a clock enable.
- Undefined: tick port and logic are absent; port list is clock, reset, clk_i only.

Decomposition:
- Package df_pkg:
  - localparam DF_DIV_MIN=1;
  - function df_cw(int div) returning max(1, $clog2(div)), used for CW;
  - localparam DF_DIV_1HZ_50M=25000000 as a shared constant.
- One natural sub-module: df_modn_counter, a mod-N counter with asynchronous active-low clear and a wrap strobe.
  - df_clk_div instantiates it and performs the toggle and tick registration.

Test Plan:
- Reset hold: DIV=4, reset=0 for 3 clocks -> clk_i=0 throughout, cnt=0. Release -> clk_i rises on the 4th rising edge and falls on the 8th; period 8 cycles over 10 periods.
- DIV=1: after release -> clk_i toggles on every rising edge (0,1,0,1…). With DF_TICK_EN, tick stays 1 after the first edge.
- Mid-count reset: DIV=5, assert reset asynchronously between edges while clk_i=1 at cnt=2 -> clk_i drops to 0 immediately, without waiting for an edge. After release, the next rise comes exactly 5 edges later.
- Duty cycle: DIV=7 over 20 periods -> high time = low time = 7 cycles each, with no drift.
- DF_TICK_EN with DIV=3 -> tick pulses one cycle each time clk_i changes; 2 pulses per 6-cycle period. Without the macro the port does not exist (compile check).
- Elaboration: DIV=25000000 -> CW=25 and clk_i toggles on edge 25000000. DIV=0 -> elaboration error.
